// File: rtl/vga_capture_pkg.sv
// Shared VGA timing constants and capture FSM state type.
// Timing values are the 640x480 link defaults; the capture block takes them as parameters.
package vga_capture_pkg;

  localparam int unsigned CLK_PER_PIX_D  = 2;
  localparam int unsigned SAMPLE_PHASE_D = 1;
  localparam int unsigned H_TOTAL_D      = 800;
  localparam int unsigned V_TOTAL_D      = 525;
  localparam int unsigned H_ACT_START_D  = 112;
  localparam int unsigned H_ACT_D        = 640;
  localparam int unsigned V_ACT_START_D  = 12;
  localparam int unsigned V_ACT_D        = 480;
  localparam int unsigned LOCK_FRAMES_D  = 2;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_TRACK,
    ST_LOCKED
  } cap_state_t;

endpackage

// File: rtl/vga_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
module vga_edge_sync (
  input  logic clk_50MHz,
  input  logic RESET,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk_50MHz) begin
    if (RESET) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/vga_capture.sv
// VGA loopback receiver: recovers pixel coordinates/colour from hsync/vsync/RGB,
// checks line and frame lengths and reports sync lock.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned CLK_PER_PIX  = CLK_PER_PIX_D,
  parameter int unsigned SAMPLE_PHASE = SAMPLE_PHASE_D,
  parameter int unsigned H_TOTAL      = H_TOTAL_D,
  parameter int unsigned V_TOTAL      = V_TOTAL_D,
  parameter int unsigned H_ACT_START  = H_ACT_START_D,
  parameter int unsigned H_ACT        = H_ACT_D,
  parameter int unsigned V_ACT_START  = V_ACT_START_D,
  parameter int unsigned V_ACT        = V_ACT_D,
  parameter int unsigned LOCK_FRAMES  = LOCK_FRAMES_D
) (
  input  logic       clk_50MHz,
  input  logic       RESET,
  input  logic       hs_vga,
  input  logic       vs_vga,
  input  logic [2:0] RED,
  input  logic [2:0] GREEN,
  input  logic [1:0] BLUE,
  output logic [9:0] PIX_X,
  output logic [8:0] PIX_Y,
  output logic [7:0] PIX_COLOR,
  output logic       PIX_VALID,
  output logic       FRAME_START,
  output logic       LOCKED,
  output logic       SYNC_ERR
);

  localparam int unsigned PW = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;
  localparam int unsigned CW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

  localparam logic [PW-1:0] PH_LAST   = PW'(CLK_PER_PIX - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PHASE);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LOCK_FRAMES - 1);
  localparam logic [10:0]   HT        = 11'(H_TOTAL);
  localparam logic [10:0]   VT        = 11'(V_TOTAL);
  localparam logic [9:0]    HA_BEG    = 10'(H_ACT_START);
  localparam logic [9:0]    HA_END    = 10'(H_ACT_START + H_ACT);
  localparam logic [9:0]    VA_BEG    = 10'(V_ACT_START);
  localparam logic [9:0]    VA_END    = 10'(V_ACT_START + V_ACT);

  logic          hs_rise;
  logic          vs_rise;
  logic [7:0]    rgb_d1, rgb_d2, rgb_d3;
  logic [PW-1:0] phase;
  logic [9:0]    hcnt;
  logic [9:0]    vcnt;
  logic          vs_pend;
  logic          h_ref;
  logic          v_ref;
  cap_state_t    state, state_nxt;
  logic [CW-1:0] good_cnt, good_cnt_nxt;
  logic          frame_edge;
  logic          line_err;
  logic          frame_err;
  logic          mismatch;
  logic          sample;

  vga_edge_sync u_hs_sync (
    .clk_50MHz (clk_50MHz),
    .RESET     (RESET),
    .din       (hs_vga),
    .rise      (hs_rise)
  );

  vga_edge_sync u_vs_sync (
    .clk_50MHz (clk_50MHz),
    .RESET     (RESET),
    .din       (vs_vga),
    .rise      (vs_rise)
  );

  // Counters are registered from the edge detector, so they describe the cycle
  // one behind the sync stage; the third colour stage keeps the RGB aligned with them.
  always_ff @(posedge clk_50MHz) begin
    if (RESET) begin
      rgb_d1 <= '0;
      rgb_d2 <= '0;
      rgb_d3 <= '0;
    end else begin
      rgb_d1 <= {RED, GREEN, BLUE};
      rgb_d2 <= rgb_d1;
      rgb_d3 <= rgb_d2;
    end
  end

  assign frame_edge = hs_rise & (vs_rise | vs_pend);
  assign line_err   = hs_rise & h_ref & (({1'b0, hcnt} + 11'd1) != HT);
  assign frame_err  = frame_edge & v_ref & (state != ST_SEARCH) &
                      (({1'b0, vcnt} + 11'd1) != VT);
  assign mismatch   = line_err | frame_err;
  assign sample     = (phase == PH_SAMPLE) &&
                      (hcnt >= HA_BEG) && (hcnt < HA_END) &&
                      (vcnt >= VA_BEG) && (vcnt < VA_END);

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    unique case (state)
      ST_SEARCH: begin
        if (vs_rise && !mismatch) begin
          state_nxt    = ST_TRACK;
          good_cnt_nxt = '0;
        end
      end
      ST_TRACK: begin
        if (mismatch) begin
          state_nxt = ST_SEARCH;
        end else if (frame_edge && v_ref) begin
          if (good_cnt == CNT_LAST) state_nxt = ST_LOCKED;
          else                      good_cnt_nxt = good_cnt + CW'(1);
        end
      end
      ST_LOCKED: begin
        if (mismatch) state_nxt = ST_SEARCH;
      end
      default: state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (RESET) begin
      state       <= ST_SEARCH;
      good_cnt    <= '0;
      phase       <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      vs_pend     <= 1'b0;
      h_ref       <= 1'b0;
      v_ref       <= 1'b0;
      PIX_X       <= '0;
      PIX_Y       <= '0;
      PIX_COLOR   <= '0;
      PIX_VALID   <= 1'b0;
      FRAME_START <= 1'b0;
      SYNC_ERR    <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;

      if (hs_rise) begin
        phase <= '0;
        hcnt  <= '0;
      end else if (phase == PH_LAST) begin
        phase <= '0;
        if (hcnt != '1) hcnt <= hcnt + 10'd1;
      end else begin
        phase <= phase + PW'(1);
      end

      // A vsync rise may precede its hsync rise by one cycle.
      vs_pend <= vs_rise & ~hs_rise;
      if (frame_edge)                vcnt <= '0;
      else if (hs_rise && vcnt != '1) vcnt <= vcnt + 10'd1;

      if (hs_rise) h_ref <= 1'b1;

      if (mismatch)        v_ref <= 1'b0;
      else if (frame_edge) v_ref <= 1'b1;

      FRAME_START <= vs_rise;
      SYNC_ERR    <= mismatch;
      PIX_VALID   <= sample && (state == ST_LOCKED);
      if (sample) begin
        PIX_X     <= hcnt - HA_BEG;
        PIX_Y     <= 9'(vcnt - VA_BEG);
        PIX_COLOR <= rgb_d3;
      end
    end
  end

  assign LOCKED = (state == ST_LOCKED);

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 20x10 timing (12x6 active area),
// driven by a small behavioural display timing generator.
module tb_vga_capture;

  localparam int CPP = 2;
  localparam int HT  = 20;
  localparam int VT  = 10;
  localparam int HAS = 4;
  localparam int HA  = 12;
  localparam int VAS = 2;
  localparam int VA  = 6;
  localparam int FRM = HT * VT * CPP;

  logic       clk_50MHz = 1'b0;
  logic       RESET;
  logic       hs_vga, vs_vga;
  logic [2:0] RED, GREEN;
  logic [1:0] BLUE;
  logic [9:0] PIX_X;
  logic [8:0] PIX_Y;
  logic [7:0] PIX_COLOR;
  logic       PIX_VALID, FRAME_START, LOCKED, SYNC_ERR;

  int n_chk = 0;
  int n_bad = 0;

  // generator controls (owned by the main sequence)
  bit mode = 1'b0;
  int drop_line = -1;
  int short_line = -1;
  int gx = 0, gy = 0, gph = 0;

  // monitor state (owned by the monitor)
  int pv_cnt = 0, cbad = 0, fx = 0, fy = 0, lx = 0, ly = 0, err_cnt = 0;
  int fr_cnt = 0, fr_cbad = 0, fr_fx = 0, fr_fy = 0, fr_lx = 0, fr_ly = 0;

  always #5 clk_50MHz = ~clk_50MHz;

  vga_capture #(
    .CLK_PER_PIX  (CPP),
    .SAMPLE_PHASE (1),
    .H_TOTAL      (HT),
    .V_TOTAL      (VT),
    .H_ACT_START  (HAS),
    .H_ACT        (HA),
    .V_ACT_START  (VAS),
    .V_ACT        (VA),
    .LOCK_FRAMES  (2)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .RESET       (RESET),
    .hs_vga      (hs_vga),
    .vs_vga      (vs_vga),
    .RED         (RED),
    .GREEN       (GREEN),
    .BLUE        (BLUE),
    .PIX_X       (PIX_X),
    .PIX_Y       (PIX_Y),
    .PIX_COLOR   (PIX_COLOR),
    .PIX_VALID   (PIX_VALID),
    .FRAME_START (FRAME_START),
    .LOCKED      (LOCKED),
    .SYNC_ERR    (SYNC_ERR)
  );

  initial begin : gen
    logic [7:0] pix;
    bit act;
    hs_vga = 1'b0;
    vs_vga = 1'b0;
    {RED, GREEN, BLUE} = 8'h00;
    forever begin
      @(negedge clk_50MHz);
      hs_vga = (gx < 2) && (gy != drop_line);
      vs_vga = (gy == 0);
      act = (gx >= HAS) && (gx < HAS + HA) && (gy >= VAS) && (gy < VAS + VA);
      pix = !act ? 8'h00 : (mode ? 8'(gx - HAS) : 8'hA5);
      {RED, GREEN, BLUE} = pix;
      gph++;
      if (gph == CPP) begin
        gph = 0;
        gx++;
        if (gx == ((gy == short_line) ? HT - 1 : HT)) begin
          gx = 0;
          gy = (gy == VT - 1) ? 0 : gy + 1;
        end
      end
    end
  end

  always @(negedge clk_50MHz) begin
    if (FRAME_START) begin
      fr_cnt  <= pv_cnt;
      fr_cbad <= cbad;
      fr_fx   <= fx;
      fr_fy   <= fy;
      fr_lx   <= lx;
      fr_ly   <= ly;
      pv_cnt  <= 0;
      cbad    <= 0;
    end else if (PIX_VALID) begin
      if (pv_cnt == 0) begin
        fx <= int'(PIX_X);
        fy <= int'(PIX_Y);
      end
      lx     <= int'(PIX_X);
      ly     <= int'(PIX_Y);
      pv_cnt <= pv_cnt + 1;
      if (PIX_COLOR != (mode ? PIX_X[7:0] : 8'hA5)) cbad <= cbad + 1;
    end
    if (SYNC_ERR) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"},     32'(PIX_X),       0);
    chk({tag, "_y"},     32'(PIX_Y),       0);
    chk({tag, "_color"}, 32'(PIX_COLOR),   0);
    chk({tag, "_valid"}, 32'(PIX_VALID),   0);
    chk({tag, "_fs"},    32'(FRAME_START), 0);
    chk({tag, "_lock"},  32'(LOCKED),      0);
    chk({tag, "_err"},   32'(SYNC_ERR),    0);
  endtask

  task automatic wait_fs(output bit ok, output int pv);
    ok = 1'b0;
    pv = 0;
    for (int i = 0; i < 2 * FRM; i++) begin
      @(posedge clk_50MHz); #1;
      if (FRAME_START) begin
        ok = 1'b1;
        break;
      end
      if (PIX_VALID) pv++;
    end
  endtask

  task automatic wait_err(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < FRM; i++) begin
      @(posedge clk_50MHz); #1;
      if (SYNC_ERR) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pos(input int y, input int x);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * FRM; i++) begin
      @(posedge clk_50MHz); #1;
      if (gy == y && gx == x) begin
        ok = 1'b1;
        break;
      end
    end
    chk("pos_reached", 32'(ok), 1);
  endtask

  // Three frame starts: tracking, one good frame, then locked.
  task automatic lock_seq(input string tag, output int pv_first);
    bit ok;
    int pv;
    wait_fs(ok, pv_first);
    chk({tag, "_fs1"}, 32'(ok), 1);
    chk({tag, "_lk1"}, 32'(LOCKED), 0);
    wait_fs(ok, pv);
    chk({tag, "_fs2"}, 32'(ok), 1);
    chk({tag, "_lk2"}, 32'(LOCKED), 0);
    wait_fs(ok, pv);
    chk({tag, "_fs3"}, 32'(ok), 1);
    chk({tag, "_lk3"}, 32'(LOCKED), 1);
  endtask

  task automatic settle();
    @(negedge clk_50MHz); #1;
  endtask

  initial begin : main
    bit ok;
    int pv;
    int e0;

    RESET = 1'b1;
    repeat (5) @(posedge clk_50MHz);
    #1;
    chk_zero("reset");

    wait_pos(5, 10);
    RESET = 1'b0;
    lock_seq("lock", pv);
    chk("lock_no_err", 32'(err_cnt), 0);

    // constant colour frame
    wait_fs(ok, pv);
    chk("a5_fs", 32'(ok), 1);
    settle();
    chk("a5_count",  32'(fr_cnt),  HA * VA);
    chk("a5_first_x", 32'(fr_fx),  0);
    chk("a5_first_y", 32'(fr_fy),  0);
    chk("a5_last_x",  32'(fr_lx),  HA - 1);
    chk("a5_last_y",  32'(fr_ly),  VA - 1);
    chk("a5_color",   32'(fr_cbad), 0);

    // colour = x pattern frame
    mode = 1'b1;
    wait_fs(ok, pv);
    chk("pat_fs", 32'(ok), 1);
    settle();
    chk("pat_count", 32'(fr_cnt),  HA * VA);
    chk("pat_color", 32'(fr_cbad), 0);
    chk("pat_no_err", 32'(err_cnt), 0);
    mode = 1'b0;

    // missing hsync pulse on line 4
    e0 = err_cnt;
    drop_line = 4;
    wait_err(ok);
    chk("drop_err", 32'(ok), 1);
    chk("drop_unlock", 32'(LOCKED), 0);
    drop_line = -1;
    lock_seq("drop_relock", pv);
    chk("drop_no_pix", 32'(pv), 0);
    chk("drop_err_once", 32'(err_cnt - e0), 1);

    // one line of HT-1 pixels
    short_line = 5;
    wait_err(ok);
    chk("short_err", 32'(ok), 1);
    chk("short_unlock", 32'(LOCKED), 0);
    short_line = -1;
    lock_seq("short_relock", pv);

    // one-cycle reset mid-frame while locked
    wait_pos(5, 10);
    chk("pre_rst_lock", 32'(LOCKED), 1);
    RESET = 1'b1;
    @(posedge clk_50MHz); #1;
    chk_zero("midrst");
    RESET = 1'b0;
    lock_seq("rst_relock", pv);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
